// File: rtl/store_pkg.sv
// Shared types and constants for the store lane packer.
package store_pkg;

    localparam int unsigned BUS_XLEN = 32;
    localparam int unsigned STRB_W   = BUS_XLEN / 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1
    } store_state_e;

    function automatic logic [3:0] size_mask(input store_size_e size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_packer_if.sv
// Store request and data-memory write port bundle; slave is the packer's view.
interface store_lane_packer_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]       req_data;
    logic [1:0]            req_size;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN/8-1:0]     mem_wstrb;
    logic                  mem_last;
    logic                  err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_last, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_last, err
    );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane placement: masks store data to its size and shifts data
// and strobes into an 8-byte window spanning two bus words.
module store_lane_shift
    import store_pkg::*;
(
    input  logic [31:0]  data,
    input  logic [1:0]   off,
    input  store_size_e  size,
    output logic [63:0]  wide_data,
    output logic [7:0]   wide_strb,
    output logic         split
);
    logic [3:0]  mask;
    logic [31:0] masked;

    always_comb begin
        mask   = size_mask(size);
        masked = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) masked[i*8 +: 8] = data[i*8 +: 8];
        end
        wide_data = {32'h0, masked} << {off, 3'b000};
        wide_strb = {4'h0, mask} << off;
        split     = |wide_strb[7:4];
    end
endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: positions SB/SH/SW data on a word-aligned write bus,
// splitting word-crossing stores into two beats. Define STORE_MISALIGN_TRAP_EN
// to reject misaligned half/word stores instead of splitting them.
module store_lane_packer
    import store_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    store_lane_packer_if.slave bus
);
    store_state_e          state_q, state_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;
    logic                  mem_last_q, mem_last_d;
    logic                  err_q, err_d;
`ifndef STORE_MISALIGN_TRAP_EN
    logic [XLEN-1:0]       b1_wdata_q, b1_wdata_d;
    logic [STRB_W-1:0]     b1_wstrb_q, b1_wstrb_d;
`endif

    store_size_e size;
    logic [63:0] wide_data;
    logic [7:0]  wide_strb;
    logic        split;
    logic        reject;

    assign size = store_size_e'(bus.req_size);

    store_lane_shift u_shift (
        .data      (bus.req_data),
        .off       (bus.req_addr[1:0]),
        .size      (size),
        .wide_data (wide_data),
        .wide_strb (wide_strb),
        .split     (split)
    );

    always_comb begin
        reject = (size == SZ_ILLEGAL);
`ifdef STORE_MISALIGN_TRAP_EN
        if ((size == SZ_HALF && bus.req_addr[0]) ||
            (size == SZ_WORD && bus.req_addr[1:0] != 2'b00)) reject = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_last_d  = mem_last_q;
        err_d       = 1'b0;
`ifndef STORE_MISALIGN_TRAP_EN
        b1_wdata_d  = b1_wdata_q;
        b1_wstrb_d  = b1_wstrb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = wide_data[31:0];
                        mem_wstrb_d = wide_strb[3:0];
`ifndef STORE_MISALIGN_TRAP_EN
                        mem_last_d  = !split;
                        b1_wdata_d  = wide_data[63:32];
                        b1_wstrb_d  = wide_strb[7:4];
`else
                        mem_last_d  = 1'b1;
`endif
                    end
                end
            end
            S_BEAT0: begin
                if (bus.mem_ready) begin
`ifndef STORE_MISALIGN_TRAP_EN
                    // beat0 not being last is exactly the split condition
                    if (!mem_last_q) begin
                        state_d     = S_BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
                        mem_wdata_d = b1_wdata_q;
                        mem_wstrb_d = b1_wstrb_q;
                        mem_last_d  = 1'b1;
                    end else
`endif
                    begin
                        state_d     = S_IDLE;
                        mem_valid_d = 1'b0;
                    end
                end
            end
`ifndef STORE_MISALIGN_TRAP_EN
            S_BEAT1: begin
                if (bus.mem_ready) begin
                    state_d     = S_IDLE;
                    mem_valid_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_last_q  <= 1'b0;
            err_q       <= 1'b0;
`ifndef STORE_MISALIGN_TRAP_EN
            b1_wdata_q  <= '0;
            b1_wstrb_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_last_q  <= mem_last_d;
            err_q       <= err_d;
`ifndef STORE_MISALIGN_TRAP_EN
            b1_wdata_q  <= b1_wdata_d;
            b1_wstrb_q  <= b1_wstrb_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_last  = mem_last_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_store_lane_packer.sv
// Self-checking bench for store_lane_packer; expected beats come from a
// byte-by-byte placement model of each store.
module tb_store_lane_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    store_lane_packer_if #(.XLEN(32), .ADDR_WIDTH(32)) bus ();

    store_lane_packer #(.XLEN(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit          exp_rej;
    int          exp_n;
    logic [31:0] exp_addr  [2];
    logic [31:0] exp_wdata [2];
    logic [3:0]  exp_wstrb [2];

    // Each byte of the store lands in whichever word its own byte address falls in.
    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        int nbytes;
        logic [31:0] a, base;
        int w;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_rej = (size == 2'd3);
`ifdef STORE_MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) exp_rej = 1'b1;
`endif
        base = addr & 32'hFFFF_FFFC;
        exp_addr[0] = base;
        exp_addr[1] = base + 32'd4;
        for (int k = 0; k < 2; k++) begin
            exp_wdata[k] = '0;
            exp_wstrb[k] = '0;
        end
        for (int i = 0; i < nbytes; i++) begin
            a = addr + 32'(i);
            w = ((a & 32'hFFFF_FFFC) == base) ? 0 : 1;
            exp_wdata[w][a[1:0]*8 +: 8] = data[i*8 +: 8];
            exp_wstrb[w][a[1:0]]        = 1'b1;
        end
        exp_n = (exp_wstrb[1] != 4'b0) ? 2 : 1;
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input int stall);
        model_store(addr, size, data);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL req_ready_idle got=%b exp=1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_data  = $urandom;
        bus.req_addr  = $urandom;
        if (exp_rej) begin
            total++;
            if (bus.err !== 1'b1 || bus.mem_valid !== 1'b0) begin
                bad++; $display("FAIL reject_pulse addr=%h err=%b valid=%b exp err=1 valid=0", addr, bus.err, bus.mem_valid);
            end
            @(negedge clk);
            total++;
            if (bus.err !== 1'b0 || bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                bad++; $display("FAIL reject_after err=%b valid=%b ready=%b exp 0 0 1", bus.err, bus.mem_valid, bus.req_ready);
            end
        end else begin
            for (int b = 0; b < exp_n; b++) begin
                for (int s = 0; s <= stall; s++) begin
                    bus.mem_ready = (s == stall);
                    total++;
                    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== exp_addr[b] ||
                        bus.mem_wdata !== exp_wdata[b] || bus.mem_wstrb !== exp_wstrb[b] ||
                        bus.mem_last !== (b == exp_n - 1) || bus.req_ready !== 1'b0 || bus.err !== 1'b0) begin
                        bad++;
                        $display("FAIL beat%0d a=%h sz=%0d d=%h cyc=%0d got v=%b ad=%h wd=%h st=%b l=%b rdy=%b exp v=1 ad=%h wd=%h st=%b l=%b rdy=0",
                                 b, addr, size, data, s, bus.mem_valid, bus.mem_addr, bus.mem_wdata,
                                 bus.mem_wstrb, bus.mem_last, bus.req_ready,
                                 exp_addr[b], exp_wdata[b], exp_wstrb[b], (b == exp_n - 1));
                    end
                    @(negedge clk);
                end
            end
            bus.mem_ready = 1'b0;
            total++;
            if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                bad++; $display("FAIL store_done valid=%b ready=%b exp 0 1", bus.mem_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
            bus.mem_wstrb !== 4'h0 || bus.mem_last !== 1'b0 || bus.err !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_vals v=%b a=%h d=%h s=%b l=%b e=%b r=%b exp all 0, ready 1",
                     bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_last, bus.err, bus.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_store(32'h0000_1003, 2'd0, 32'hFFFF_FFAB, 0);
        run_store(32'h0000_1002, 2'd1, 32'h0000_1234, 0);
        run_store(32'h0000_1002, 2'd2, 32'hDEAD_BEEF, 0);
        run_store(32'h0000_1003, 2'd1, 32'hFFFF_CAFE, 1);
        run_store(32'h0000_1001, 2'd2, 32'h1122_3344, 0);
        run_store(32'h0000_3000, 2'd3, 32'h5555_5555, 0);
    endtask

    task automatic test_backpressure();
        run_store(32'h0000_2000, 2'd2, 32'hA5A5_0F0F, 3);
        run_store(32'h0000_2003, 2'd2, 32'h0102_0304, 2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_data  = 32'h1122_3344;
`ifndef STORE_MISALIGN_TRAP_EN
        bus.req_addr  = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        total++;
        if (bus.mem_addr !== 32'hFFFF_FFFC || bus.mem_last !== 1'b0) begin
            bad++; $display("FAIL wrap_beat0 addr=%h last=%b exp fffffffc 0", bus.mem_addr, bus.mem_last);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        total++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_last !== 1'b1) begin
            bad++; $display("FAIL wrap_beat1 v=%b addr=%h last=%b exp 1 00000000 1", bus.mem_valid, bus.mem_addr, bus.mem_last);
        end
`else
        bus.req_addr  = 32'h0000_2000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_addr !== 32'h0 ||
            bus.mem_wstrb !== 4'h0 || bus.mem_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid v=%b r=%b a=%h s=%b l=%b exp 0 1 0 0 0",
                     bus.mem_valid, bus.req_ready, bus.mem_addr, bus.mem_wstrb, bus.mem_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL after_reset v=%b r=%b exp 0 1", bus.mem_valid, bus.req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            if (n % 4 == 0) a[31:4] = 28'hFFFF_FFF;
            run_store(a, 2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        run_store(32'h0000_4000, 2'd2, 32'hCAFE_F00D, 0);
        run_store(32'h0000_4004, 2'd0, 32'h0000_0077, 0);
        run_store(32'h0000_4006, 2'd1, 32'h0000_BEEF, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
